memory_responder: RTL
=====================

MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, locator_bus width; array depth is 2**ADDR_WIDTH words.
REQ-002 Parameter DATA_WIDTH, default 16, data word width.
REQ-003 Parameter WAIT_STATES, default 2, extra access cycles (used only with MEMRESP_WAIT_STATES_EN).
REQ-004 clk  input  1  sole clock; all logic on posedge.
REQ-005 rst_n  input  1  reset; synchronous and active-low.
REQ-006 memory_request  input  1  initiator request level.
REQ-007 memory_mode  input  1  1 = write, 0 = read.
REQ-008 locator_bus  input  ADDR_WIDTH  word address.
REQ-009 write_bus  input  DATA_WIDTH  write data.
REQ-010 memory_response  output  1  completion pulse; its falling edge tells the initiator to drop memory_request.
REQ-011 read_bus  output  DATA_WIDTH  read data.

Function
REQ-012 FSM states: IDLE, ACCESS, ACK, RELEASE.
REQ-013 IDLE: memory_request=1 at a posedge -> latch memory_mode, locator_bus and write_bus; go to ACCESS.
REQ-014 ACCESS lasts 1 cycle without the macro, 1+WAIT_STATES cycles with it; on its last posedge perform the latched write or read, then go to ACK.
REQ-015 ACK: memory_response=1 for exactly one cycle, then go to RELEASE.
REQ-016 Latency: request sampled at edge E0 -> memory_response high from edge E0+1+W to E0+2+W, where W=0 without the macro and W=WAIT_STATES with it.
REQ-017 RELEASE: memory_response=0; go to IDLE only after sampling memory_request=0; a held request is never serviced twice.
REQ-018 Read: read_bus is valid from the ACK edge and holds until the next read completes.
REQ-019 Write: read_bus is unchanged by the write.
REQ-020 Input changes after the latch edge are ignored for the current transaction.
REQ-021 If memory_request drops during ACCESS, the operation completes and ACK is still issued; RELEASE then exits on the next cycle.
REQ-022 All addresses 0 to 2**ADDR_WIDTH-1 are valid; there is no wrap or truncation inside the array.
REQ-023 Back-to-back requests: minimum spacing is one IDLE cycle after RELEASE.

Reset
REQ-024 rst_n=0 at a posedge -> state=IDLE, memory_response=0, read_bus=0, wait counter=0.
REQ-025 Reset is not applied to array contents.
REQ-026 Reset during ACCESS before the commit edge aborts the transaction; no write occurs.
REQ-027 After reset is released, a request that is still held is treated as new.

Configuration
REQ-028 Macro MEMRESP_WAIT_STATES_EN: when defined, ACCESS includes a WAIT_STATES down-counter.
REQ-029 When MEMRESP_WAIT_STATES_EN is undefined, the counter and the WAIT_STATES logic are absent and ACCESS is fixed at 1 cycle.

Structure
REQ-030 A shared package holds:
- MODE_READ=0 and MODE_WRITE=1 constants;
- the default address and data widths;
- the FSM state enum typedef.
REQ-031 One sub-module, memory_bank: synchronous single-port RAM with one write or read per enabled cycle; memory_responder instantiates it once.

Verification
REQ-032 Write 0xBBBB to address 0x0000, then read 0x0000 -> read_bus=0xBBBB; response pulse exactly one cycle per transaction.
REQ-033 Without the macro, request sampled at edge 10 -> memory_response high between edges 11 and 12; with the macro and WAIT_STATES=2 -> high between edges 13 and 14.
REQ-034 Hold memory_request=1 for 20 cycles after the pulse -> exactly one pulse and one write; a second pulse appears only after request goes low then high again.
REQ-035 Assert rst_n=0 during ACCESS of a write of 0x1234 to 0x0005 -> address 0x0005 keeps its prior value; outputs are 0 and state is IDLE.
REQ-036 Write 0xD000 to address 0xFFFF and 0x1000 to 0x0000, then read both -> 0xD000 and 0x1000; there is no aliasing.
REQ-037 Change locator_bus and write_bus one cycle after acceptance -> the originally latched address and data are used.

Source files
------------

// File: rtl/memory_responder_pkg.sv
// Shared definitions for the memory responder: access-mode encodings,
// default bus widths and the handshake FSM state type.
package memory_responder_pkg;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    localparam int DEFAULT_ADDR_WIDTH = 16;
    localparam int DEFAULT_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK,
        RELEASE
    } state_t;

endpackage

// File: rtl/memory_responder_bank.sv
// memory_bank: synchronous single-port RAM, one read or one write per
// enabled cycle. The array itself is never reset; only the read data
// register returns to zero under reset.
module memory_bank
    import memory_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

    // Array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Read data register: loads only on an enabled read, so a write leaves it untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/memory_responder.sv
// memory_responder: request/response handshake front end for a single-port
// RAM. A request is latched in IDLE, performed at the end of ACCESS,
// acknowledged by a one-cycle memory_response pulse in ACK, and RELEASE
// waits for the initiator to drop its request before accepting another.
// Optional feature macro: MEMRESP_WAIT_STATES_EN stretches ACCESS by
// WAIT_STATES extra cycles using a down-counter.
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  memory_request,
    input  logic                  memory_mode,
    input  logic [ADDR_WIDTH-1:0] locator_bus,
    input  logic [DATA_WIDTH-1:0] write_bus,
    output logic                  memory_response,
    output logic [DATA_WIDTH-1:0] read_bus
);

    state_t                state;
    state_t                state_next;
    logic                  mode_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  access_done;
    logic                  bank_en;
    logic                  accept;

    assign accept = (state == IDLE) && memory_request;

`ifdef MEMRESP_WAIT_STATES_EN
    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    logic [CNT_W-1:0] wait_cnt;

    // Wait-state down-counter: armed on acceptance, ACCESS ends when it reaches zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (accept) begin
            wait_cnt <= CNT_W'(WAIT_STATES);
        end else if ((state == ACCESS) && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    assign access_done = (wait_cnt == '0);
`else
    assign access_done = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the transaction on acceptance so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q <= MODE_READ;
            addr_q <= '0;
            data_q <= '0;
        end else if (accept) begin
            mode_q <= memory_mode;
            addr_q <= locator_bus;
            data_q <= write_bus;
        end
    end

    // Next-state logic plus the response pulse and the RAM commit strobe.
    always_comb begin
        state_next      = state;
        memory_response = 1'b0;
        bank_en         = 1'b0;
        case (state)
            IDLE: begin
                if (memory_request) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (access_done) begin
                    bank_en    = 1'b1;
                    state_next = ACK;
                end
            end
            ACK: begin
                memory_response = 1'b1;
                state_next      = RELEASE;
            end
            RELEASE: begin
                if (!memory_request) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Reset on the commit edge aborts the access, so the strobe is masked by rst_n.
    memory_bank #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bank (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bank_en && rst_n),
        .we    (mode_q == MODE_WRITE),
        .addr  (addr_q),
        .wdata (data_q),
        .rdata (read_bus)
    );

endmodule
